// File: rtl/encap_scheduler.sv
// Round-robin scheduler sharing one packet encapsulator between N_SRC trace sources.
// Registers the winning packet and decides per packet whether a timestamp extension is emitted.

package encap_pkg;
    localparam int FLOW_LEN    = 4;
    localparam int P_LEN       = 8;
    localparam int PAYLOAD_LEN = 32;
    localparam int T_LEN       = 16;
endpackage

module encap_scheduler
    import encap_pkg::*;
#(
    parameter int N_SRC     = 2,
    parameter int TS_PERIOD = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_SRC-1:0]                    src_valid_i,
    output logic [N_SRC-1:0]                    src_ready_o,
    input  logic [N_SRC-1:0][P_LEN-1:0]         src_length_i,
    input  logic [N_SRC-1:0][PAYLOAD_LEN-1:0]   src_payload_i,
    input  logic [T_LEN-1:0]                    timestamp_i,
    input  logic                                ts_force_i,
    input  logic                                ready_i,
    output logic                                valid_o,
    output logic [P_LEN-1:0]                    packet_length_o,
    output logic [FLOW_LEN-1:0]                 flow_o,
    output logic                                timestamp_present_o,
    output logic [T_LEN-1:0]                    timestamp_o,
    output logic [PAYLOAD_LEN-1:0]              trace_payload_o
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = (TS_PERIOD > 1) ? $clog2(TS_PERIOD) : 1;
    localparam bit PERIODIC = (TS_PERIOD != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = PERIODIC ? CNT_W'(TS_PERIOD - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] grant_next;
    logic [IDX_W:0]   cand;
    logic             any_valid;
    logic             load_en;
    logic             load;
    logic             ts;
    logic             first_pkt;
    logic             force_pend;
    logic [CNT_W-1:0] ts_cnt;

    // Walk from the highest offset down so the candidate closest to rr_ptr wins.
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(N_SRC)) begin
                cand = cand - (IDX_W + 1)'(N_SRC);
            end
            if (src_valid_i[cand[IDX_W-1:0]]) begin
                grant     = cand[IDX_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign grant_next = (grant == LAST_IDX) ? '0 : grant + 1'b1;
    assign load_en    = !valid_o || ready_i;
    assign load       = load_en && any_valid;

    // flow_o only changes on a load, so it doubles as the flow of the last emitted packet.
    assign ts = first_pkt
             || (FLOW_LEN'(grant) != flow_o)
             || (PERIODIC && (ts_cnt == CNT_MAX))
             || force_pend
             || ts_force_i;

    always_comb begin
        src_ready_o = '0;
        if (load) begin
            src_ready_o[grant] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o             <= 1'b0;
            packet_length_o     <= '0;
            flow_o              <= '0;
            timestamp_present_o <= 1'b0;
            timestamp_o         <= '0;
            trace_payload_o     <= '0;
            rr_ptr              <= '0;
            first_pkt           <= 1'b1;
            ts_cnt              <= '0;
            force_pend          <= 1'b0;
        end else begin
            if (load) begin
                valid_o             <= 1'b1;
                packet_length_o     <= src_length_i[grant];
                trace_payload_o     <= src_payload_i[grant];
                flow_o              <= FLOW_LEN'(grant);
                timestamp_present_o <= ts;
                timestamp_o         <= ts ? timestamp_i : '0;
                first_pkt           <= 1'b0;
                rr_ptr              <= grant_next;
                if (ts) begin
                    ts_cnt <= '0;
                end else if (ts_cnt != CNT_MAX) begin
                    ts_cnt <= ts_cnt + 1'b1;
                end
            end else if (load_en) begin
                valid_o <= 1'b0;
            end

            // A force arriving with a load is consumed by that load's timestamp.
            if (load && ts) begin
                force_pend <= 1'b0;
            end else if (!load && ts_force_i) begin
                force_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_encap_scheduler.sv
// Self-checking bench for encap_scheduler: a behavioural model checked every cycle,
// plus directed scenarios with hand-computed packet sequences.

module tb_encap_scheduler;
    import encap_pkg::*;

    localparam int N_SRC     = 2;
    localparam int TS_PERIOD = 16;

    logic                              clk_i = 1'b0;
    logic                              rst_ni;
    logic [N_SRC-1:0]                  src_valid_i;
    logic [N_SRC-1:0]                  src_ready_o;
    logic [N_SRC-1:0][P_LEN-1:0]       src_length_i;
    logic [N_SRC-1:0][PAYLOAD_LEN-1:0] src_payload_i;
    logic [T_LEN-1:0]                  timestamp_i = 16'h0100;
    logic                              ts_force_i;
    logic                              ready_i;
    logic                              valid_o;
    logic [P_LEN-1:0]                  packet_length_o;
    logic [FLOW_LEN-1:0]               flow_o;
    logic                              timestamp_present_o;
    logic [T_LEN-1:0]                  timestamp_o;
    logic [PAYLOAD_LEN-1:0]            trace_payload_o;

    encap_scheduler #(.N_SRC(N_SRC), .TS_PERIOD(TS_PERIOD)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .src_valid_i         (src_valid_i),
        .src_ready_o         (src_ready_o),
        .src_length_i        (src_length_i),
        .src_payload_i       (src_payload_i),
        .timestamp_i         (timestamp_i),
        .ts_force_i          (ts_force_i),
        .ready_i             (ready_i),
        .valid_o             (valid_o),
        .packet_length_o     (packet_length_o),
        .flow_o              (flow_o),
        .timestamp_present_o (timestamp_present_o),
        .timestamp_o         (timestamp_o),
        .trace_payload_o     (trace_payload_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) timestamp_i <= timestamp_i + 16'd1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit                   m_valid;
    int                   m_flow;
    logic [P_LEN-1:0]     m_len;
    logic [PAYLOAD_LEN-1:0] m_pay;
    bit                   m_tsp;
    logic [T_LEN-1:0]     m_tsv;
    int                   m_rr;
    bit                   m_first;
    int                   m_cnt;
    bit                   m_pend;

    function automatic int find_grant(input logic [N_SRC-1:0] v, input int start);
        for (int k = 0; k < N_SRC; k++) begin
            if (v[(start + k) % N_SRC]) return (start + k) % N_SRC;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_flow = 0; m_len = '0; m_pay = '0; m_tsp = 0; m_tsv = '0;
        m_rr = 0; m_first = 1; m_cnt = 0; m_pend = 0;
    endtask

    task automatic model_step();
        int g;
        bit ts;
        g = (!m_valid || ready_i) ? find_grant(src_valid_i, m_rr) : -1;
        if (g >= 0) begin
            ts = m_first || (g != m_flow) || (m_cnt == TS_PERIOD - 1) || m_pend || ts_force_i;
            m_valid = 1;
            m_flow  = g;
            m_len   = src_length_i[g];
            m_pay   = src_payload_i[g];
            m_tsp   = ts;
            m_tsv   = ts ? timestamp_i : '0;
            m_first = 0;
            m_cnt   = ts ? 0 : ((m_cnt + 1 > TS_PERIOD - 1) ? TS_PERIOD - 1 : m_cnt + 1);
            if (ts) m_pend = 0;
            m_rr    = (g + 1) % N_SRC;
        end else begin
            if (!m_valid || ready_i) m_valid = 0;
            if (ts_force_i) m_pend = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare + accepted-packet log ----------------
    typedef struct {
        int   flow;
        int   len;
        bit   tsp;
        int   tsv;
    } pkt_t;
    pkt_t acc_log[$];

    initial begin
        int g;
        logic [N_SRC-1:0] exp_rdy;
        forever begin
            @(negedge clk_i);
            g = (!m_valid || ready_i) ? find_grant(src_valid_i, m_rr) : -1;
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("m_src_ready", src_ready_o, exp_rdy);
            check("m_valid", valid_o, m_valid);
            check("m_flow", flow_o, m_flow);
            check("m_length", packet_length_o, m_len);
            check("m_payload", trace_payload_o, m_pay);
            check("m_ts_present", timestamp_present_o, m_tsp);
            check("m_timestamp", timestamp_o, m_tsv);
            if (valid_o && ready_i) begin
                acc_log.push_back('{flow: int'(flow_o), len: int'(packet_length_o),
                                    tsp: timestamp_present_o, tsv: int'(timestamp_o)});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        src_valid_i = '0;
        ts_force_i  = 1'b0;
        ready_i     = 1'b1;
        repeat (2) step();
        rst_ni = 1'b1;
        acc_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [T_LEN-1:0] hs_ts;
        bit exp_tsp_force[11];

        rst_ni        = 1'b0;
        src_valid_i   = '0;
        ts_force_i    = 1'b0;
        ready_i       = 1'b1;
        src_length_i  = '0;
        src_payload_i = '0;

        // Reset state
        @(negedge clk_i);
        check("rst_valid", valid_o, 1'b0);
        check("rst_src_ready", src_ready_o, 2'b00);
        check("rst_length", packet_length_o, 8'd0);
        check("rst_timestamp", timestamp_o, 16'd0);

        // T1: single packet from source 0, one-cycle latency, first packet timestamped
        do_reset();
        src_length_i[0]  = 8'd5;
        src_payload_i[0] = 32'hCAFE_0001;
        src_valid_i      = 2'b01;
        @(negedge clk_i);
        check("t1_src_ready", src_ready_o, 2'b01);
        hs_ts = timestamp_i;
        step();
        src_valid_i = 2'b00;
        @(negedge clk_i);
        check("t1_valid", valid_o, 1'b1);
        check("t1_flow", flow_o, 4'd0);
        check("t1_length", packet_length_o, 8'd5);
        check("t1_ts_present", timestamp_present_o, 1'b1);
        check("t1_timestamp", timestamp_o, hs_ts);
        step();

        // T2: both sources valid -> alternate 0,1,0,1 with a timestamp on every flow change
        do_reset();
        src_length_i[0]  = 8'd3;
        src_length_i[1]  = 8'd7;
        src_payload_i[0] = 32'hA000_0000;
        src_payload_i[1] = 32'hB000_0000;
        src_valid_i      = 2'b11;
        repeat (8) step();
        src_valid_i = 2'b00;
        repeat (2) step();
        check("t2_count", acc_log.size(), 8);
        foreach (acc_log[i]) begin
            check("t2_flow", acc_log[i].flow, i % 2);
            check("t2_ts_present", acc_log[i].tsp, 1'b1);
        end

        // T3: 20 packets from source 0 -> timestamps on packets 1 and 17 only
        do_reset();
        src_valid_i = 2'b01;
        repeat (20) step();
        src_valid_i = 2'b00;
        repeat (2) step();
        check("t3_count", acc_log.size(), 20);
        foreach (acc_log[i]) begin
            check("t3_ts_present", acc_log[i].tsp, (i == 0 || i == 16) ? 1'b1 : 1'b0);
        end

        // T4: stall for 4 cycles, then the grant moves past the held flow
        do_reset();
        src_valid_i = 2'b11;
        step();
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("t4_stall_ready", src_ready_o, 2'b00);
            check("t4_stall_valid", valid_o, 1'b1);
            check("t4_stall_flow", flow_o, 4'd0);
            check("t4_stall_length", packet_length_o, 8'd3);
            step();
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        check("t4_release_grant", src_ready_o, 2'b10);
        step();
        src_valid_i = 2'b00;
        @(negedge clk_i);
        check("t4_next_flow", flow_o, 4'd1);
        step();

        // T5: force during an idle cycle, then force coincident with a load
        do_reset();
        src_valid_i = 2'b01;
        repeat (5) step();
        src_valid_i = 2'b00;
        ts_force_i  = 1'b1;
        step();
        ts_force_i  = 1'b0;
        src_valid_i = 2'b01;
        repeat (3) step();
        ts_force_i = 1'b1;
        step();
        ts_force_i = 1'b0;
        repeat (2) step();
        src_valid_i = 2'b00;
        repeat (2) step();
        exp_tsp_force = '{1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        check("t5_count", acc_log.size(), 11);
        foreach (acc_log[i]) begin
            if (i < 11) check("t5_ts_present", acc_log[i].tsp, exp_tsp_force[i]);
        end

        // T6: asynchronous reset while a packet is held under stall
        do_reset();
        src_valid_i = 2'b01;
        ready_i     = 1'b0;
        repeat (2) step();
        rst_ni      = 1'b0;
        src_valid_i = 2'b00;
        #1;
        check("t6_async_valid", valid_o, 1'b0);
        check("t6_async_length", packet_length_o, 8'd0);
        step();
        rst_ni      = 1'b1;
        ready_i     = 1'b1;
        src_valid_i = 2'b11;
        @(negedge clk_i);
        check("t6_first_grant", src_ready_o, 2'b01);
        step();
        src_valid_i = 2'b00;
        @(negedge clk_i);
        check("t6_flow", flow_o, 4'd0);
        check("t6_ts_present", timestamp_present_o, 1'b1);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encap_scheduler.md
Name: encap_scheduler

Overview:
- Shares the single packet encapsulator between N_SRC trace sources using round-robin arbitration.
- Registers the winning packet and drives the encapsulator inputs with a valid/ready handshake toward the encapsulator FIFO.
- Decides per packet whether the optional timestamp extension is present (header extend bit).
- Sits between the per-source trace packers and the encapsulator/FIFO.

Parameters:
N_SRC, 2, number of requesting sources; 2 <= N_SRC <= 2**encap_pkg::FLOW_LEN
TS_PERIOD, 16, force a timestamp after TS_PERIOD-1 consecutive non-timestamped packets; 0 disables the periodic rule

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
src_valid_i  in  N_SRC  source i has a packet
src_ready_o  out  N_SRC  source i packet consumed this cycle
src_length_i  in  N_SRC x encap_pkg::P_LEN  packet length per source
src_payload_i  in  N_SRC x encap_pkg::PAYLOAD_LEN  trace payload per source
timestamp_i  in  encap_pkg::T_LEN  free-running time value
ts_force_i  in  1  request a timestamp on the next emitted packet
ready_i  in  1  downstream accepts (encapsulator FIFO not full)
valid_o  out  1  output register holds a packet
packet_length_o  out  encap_pkg::P_LEN  to encapsulator packet_length_i
flow_o  out  encap_pkg::FLOW_LEN  granted source index, zero-extended
timestamp_present_o  out  1  to encapsulator timestamp_present_i
timestamp_o  out  encap_pkg::T_LEN  timestamp sampled at load
trace_payload_o  out  encap_pkg::PAYLOAD_LEN  granted payload

Behaviour:
- Reset values:
  - Outputs: valid_o=0; all data outputs 0; src_ready_o=0.
  - Internal state: rr_ptr=0, first_pkt=1, ts_cnt=0, force_pend=0.
- Reset is asynchronous: a packet held mid-stall is dropped.
- Load enable: load_en = !valid_o || ready_i. The output register may load in the same cycle it is accepted (1 packet/cycle throughput).
- Arbitration, when load_en and any src_valid_i:
  - Grant g = first valid index searching from rr_ptr upward, wrapping modulo N_SRC.
  - src_ready_o[g]=1 that cycle only (combinational); all other src_ready_o bits are 0.
  - Then rr_ptr <= (g+1) mod N_SRC.
- No valid source with load_en: valid_o <= 0 next cycle; rr_ptr, ts_cnt and data outputs are unchanged.
- Stall (valid_o && !ready_i): all outputs are held stable; src_ready_o=0; rr_ptr frozen.
- Latency: a source handshake at cycle t produces valid_o with that packet at t+1.
- Timestamp decision at load (ts = OR of):
  - first_pkt;
  - g != flow of the last emitted packet;
  - TS_PERIOD != 0 && ts_cnt == TS_PERIOD-1;
  - force_pend || ts_force_i.
- On load:
  - timestamp_present_o <= ts.
  - timestamp_o <= timestamp_i when ts, else 0.
  - first_pkt <= 0.
  - last_flow <= g.
  - ts_cnt <= 0 when ts, else ts_cnt+1, saturating at TS_PERIOD-1.
- force_pend:
  - Set by ts_force_i in a cycle with no load.
  - Cleared by any load with ts=1.
  - ts_force_i coincident with a load is consumed by that load (force_pend not set).
- Data outputs (packet_length_o, trace_payload_o, flow_o) are copies of the granted source, registered.
- Sources must hold length/payload stable while src_valid_i=1 and not granted.

Test Plan:
- After reset, src_valid_i=2'b01, length=5, ready_i=1 -> src_ready_o=01 at cycle 0; cycle 1: valid_o=1, flow_o=0, packet_length_o=5, timestamp_present_o=1, timestamp_o=timestamp_i sampled at cycle 0.
- Both sources valid continuously, ready_i=1 -> grants alternate 0,1,0,1; every packet has timestamp_present_o=1 (flow change); one packet per cycle.
- Source 0 only, 20 packets, TS_PERIOD=16, ready_i=1 -> timestamp_present_o=1 on packets 1 and 17 only.
- valid_o=1, ready_i=0 for 4 cycles with both sources valid -> outputs constant, src_ready_o=00; first cycle with ready_i=1 -> the next grant goes to the source after the held packet's flow.
- Single-source stream mid-period, pulse ts_force_i during an idle cycle -> next emitted packet has timestamp_present_o=1 and ts_cnt restarts from 0; a pulse coincident with a load timestamps that packet only.
- rst_ni low while valid_o=1 under stall -> valid_o=0 immediately; after release, first packet is timestamped and granted from source 0.
